serial_compare_ctrl: RTL and testbench
======================================

// Module: serial_compare_ctrl
// PURPOSE
//   Sequencer that compares two WIDTH-bit unsigned words serially, MSB first,
//   one bit per clock, using the 1-bit lesser/greater/equal cell equations.
//   Operands are captured on an accepted start. A start/busy/done handshake
//   returns a registered three-way result and the number of bit positions
//   examined. It sits between a requesting control FSM and the bit-level
//   comparator cell. It trades latency for area compared with a parallel
//   magnitude comparator.
// PARAMETERS
//   WIDTH       8  operand width in bits; legal range >= 1
//   EARLY_EXIT  1  1: stop at the first differing bit; 0: always scan all WIDTH bits
// PORTS
//   clk      in   1                      rising-edge clock
//   rst      in   1                      asynchronous, active-high reset
//   start    in   1                      request; accepted only in IDLE
//   a        in   WIDTH                  operand A; sampled on the accepting edge only
//   b        in   WIDTH                  operand B; sampled on the accepting edge only
//   busy     out  1                      high in RUN and DONE
//   done     out  1                      one-cycle pulse; the result is valid from this cycle
//   lesser   out  1                      A < B
//   greater  out  1                      A > B
//   equal    out  1                      A == B
//   nbits    out  $clog2(WIDTH+1)        bit positions examined (1..WIDTH)
// BEHAVIOUR
//   Reset (async, rst=1): state=IDLE and the index register is cleared.
//     busy, done, lesser, greater, equal, nbits and the captured operands are all 0.
//   FSM states: IDLE, RUN, DONE. The state is encoded in registers.
//     done = (state==DONE). busy = (state!=IDLE). Both are decoded from the state register.
//   IDLE, start=1 at edge E0:
//     capture a, b; idx=WIDTH-1; clear lesser/greater/equal/nbits; go to RUN.
//   IDLE, start=0: hold. The previous result stays on the outputs.
//   RUN, each edge: examine bit idx with lt=~a[idx]&b[idx], gt=a[idx]&~b[idx];
//     nbits increments.
//   - EARLY_EXIT=1:
//     - lt|gt -> latch lesser=lt, greater=gt; go to DONE.
//     - else if idx==0 -> latch equal=1; go to DONE.
//     - else idx--.
//   - EARLY_EXIT=0:
//     - the first differing bit latches lt/gt into sticky flags; later bits are ignored.
//     - at idx==0 -> go to DONE; equal=1 only if no bit differed.
//   Latency: done is high in the cycle after edge Ek, where k = nbits.
//     - EARLY_EXIT=1: k = WIDTH - (index of MSB difference), or WIDTH if the operands are equal.
//     - EARLY_EXIT=0: k = WIDTH always.
//   DONE: lasts exactly one cycle, then IDLE.
//     start is ignored in RUN and DONE; the requester must hold it or retry in IDLE.
//   Results are held stable from done until the next accepted start clears them.
//   Exactly one of lesser/greater/equal is high whenever the result is valid.
//   Changes on a/b during RUN/DONE have no effect, because the operands are captured.
//   rst asserted mid-RUN: immediate return to the reset values; no done pulse is produced.
//   WIDTH=1: a single RUN cycle; nbits=1.
//   Back-to-back: the fastest restart is start at the edge after DONE, i.e. k+2 edges after E0.
// TESTING
//   1. W=8, EE=1, a=0x80, b=0x7F
//      -> done one edge after E0; greater=1, lesser=0, equal=0, nbits=1.
//   2. W=8, EE=1, a=0x35, b=0x35
//      -> done after 8 edges; equal=1, nbits=8.
//   3. W=8, EE=0, a=0x12, b=0x13
//      -> done after 8 edges; lesser=1, nbits=8.
//      Same operands with EE=1 -> nbits=8, lesser=1.
//   4. W=8, EE=1, a=0x40 vs b=0x00, then start held high through RUN/DONE with new operands
//      -> first done: greater=1, nbits=2; start ignored until IDLE;
//         the second request is accepted on the first IDLE edge.
//   5. a=0xF0, b=0x0F; rst pulsed during RUN; a and b changed mid-RUN in a separate run
//      -> reset: all outputs 0 asynchronously, no done pulse;
//         operand change mid-RUN: result reflects the captured values.
//   6. Random sweep, W=4, both EE values, all 256 operand pairs
//      -> result matches $unsigned compare; one-hot result; nbits per the latency rule.

Source files
------------

// File: rtl/serial_compare_ctrl.sv
// Serial MSB-first magnitude comparator sequencer with a start/busy/done handshake.
// Produces a registered one-hot lesser/greater/equal result and the number of bits examined.
module serial_compare_ctrl #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned EARLY_EXIT = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [WIDTH-1:0]             a,
  input  logic [WIDTH-1:0]             b,
  output logic                         busy,
  output logic                         done,
  output logic                         lesser,
  output logic                         greater,
  output logic                         equal,
  output logic [$clog2(WIDTH+1)-1:0]   nbits
);

  localparam int unsigned NBW = $clog2(WIDTH + 1);
  localparam int unsigned IW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             lesser_q, lesser_d;
  logic             greater_q, greater_d;
  logic             equal_q, equal_d;
  logic [NBW-1:0]   nbits_q, nbits_d;

  logic             bit_lt_c;
  logic             bit_gt_c;
  logic             last_c;

  // One-bit comparator cell on the currently indexed captured bit.
  always_comb begin
    bit_lt_c = ~a_q[idx_q] &  b_q[idx_q];
    bit_gt_c =  a_q[idx_q] & ~b_q[idx_q];
    last_c   = (idx_q == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      lesser_q  <= 1'b0;
      greater_q <= 1'b0;
      equal_q   <= 1'b0;
      nbits_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      a_q       <= a_d;
      b_q       <= b_d;
      lesser_q  <= lesser_d;
      greater_q <= greater_d;
      equal_q   <= equal_d;
      nbits_q   <= nbits_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        if (EARLY_EXIT != 0) begin
          if (bit_lt_c | bit_gt_c | last_c) state_d = S_DONE;
        end else begin
          if (last_c) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: operand capture, index walk and sticky result flags.
  always_comb begin
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    lesser_d  = lesser_q;
    greater_d = greater_q;
    equal_d   = equal_q;
    nbits_d   = nbits_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d       = a;
          b_d       = b;
          idx_d     = IW'(WIDTH - 1);
          lesser_d  = 1'b0;
          greater_d = 1'b0;
          equal_d   = 1'b0;
          nbits_d   = '0;
        end
      end
      S_RUN: begin
        nbits_d = nbits_q + NBW'(1);
        if (EARLY_EXIT != 0) begin
          if (bit_lt_c | bit_gt_c) begin
            lesser_d  = bit_lt_c;
            greater_d = bit_gt_c;
          end else if (last_c) begin
            equal_d = 1'b1;
          end else begin
            idx_d = idx_q - IW'(1);
          end
        end else begin
          // Only the most significant difference decides; later bits are ignored.
          if (!(lesser_q | greater_q)) begin
            lesser_d  = bit_lt_c;
            greater_d = bit_gt_c;
          end
          if (last_c) begin
            equal_d = ~(lesser_q | greater_q | bit_lt_c | bit_gt_c);
          end else begin
            idx_d = idx_q - IW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // Handshake decoded straight from the state register.
  always_comb begin
    busy    = (state_q != S_IDLE);
    done    = (state_q == S_DONE);
    lesser  = lesser_q;
    greater = greater_q;
    equal   = equal_q;
    nbits   = nbits_q;
  end

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Directed bench for serial_compare_ctrl: W8 with both EARLY_EXIT modes plus an exhaustive W4 sweep.
module tb_serial_compare_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] start_v;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] busy_v, done_v, lt_v, gt_v, eq_v;
  logic [3:0] nb0, nb1;
  logic [2:0] nb2, nb3;

  int checks;
  int errors;

  serial_compare_ctrl #(.WIDTH(8), .EARLY_EXIT(1)) u_w8_ee1 (
    .clk(clk), .rst(rst), .start(start_v[0]), .a(a), .b(b),
    .busy(busy_v[0]), .done(done_v[0]), .lesser(lt_v[0]), .greater(gt_v[0]),
    .equal(eq_v[0]), .nbits(nb0));

  serial_compare_ctrl #(.WIDTH(8), .EARLY_EXIT(0)) u_w8_ee0 (
    .clk(clk), .rst(rst), .start(start_v[1]), .a(a), .b(b),
    .busy(busy_v[1]), .done(done_v[1]), .lesser(lt_v[1]), .greater(gt_v[1]),
    .equal(eq_v[1]), .nbits(nb1));

  serial_compare_ctrl #(.WIDTH(4), .EARLY_EXIT(1)) u_w4_ee1 (
    .clk(clk), .rst(rst), .start(start_v[2]), .a(a[3:0]), .b(b[3:0]),
    .busy(busy_v[2]), .done(done_v[2]), .lesser(lt_v[2]), .greater(gt_v[2]),
    .equal(eq_v[2]), .nbits(nb2));

  serial_compare_ctrl #(.WIDTH(4), .EARLY_EXIT(0)) u_w4_ee0 (
    .clk(clk), .rst(rst), .start(start_v[3]), .a(a[3:0]), .b(b[3:0]),
    .busy(busy_v[3]), .done(done_v[3]), .lesser(lt_v[3]), .greater(gt_v[3]),
    .equal(eq_v[3]), .nbits(nb3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Packs {busy, done, lesser, greater, equal, nbits[3:0]} for one instance.
  function automatic logic [8:0] obs(input int id);
    logic [8:0] o;
    case (id)
      0:       o = {busy_v[0], done_v[0], lt_v[0], gt_v[0], eq_v[0], nb0};
      1:       o = {busy_v[1], done_v[1], lt_v[1], gt_v[1], eq_v[1], nb1};
      2:       o = {busy_v[2], done_v[2], lt_v[2], gt_v[2], eq_v[2], 1'b0, nb2};
      default: o = {busy_v[3], done_v[3], lt_v[3], gt_v[3], eq_v[3], 1'b0, nb3};
    endcase
    return o;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start one comparison, swap the operand inputs after acceptance, and check latency/result.
  task automatic run_one(input string tag, input int id, input logic [7:0] aa, input logic [7:0] bb,
                         input logic [7:0] na, input logic [7:0] nbb,
                         input logic elt, input logic egt, input logic eeq, input int ek);
    logic [8:0] o;
    logic [6:0] exp_res;
    int n;
    bit got;
    exp_res = {elt, egt, eeq, 4'(ek)};
    a = aa;
    b = bb;
    start_v[id] = 1'b1;
    step();
    start_v[id] = 1'b0;
    a = na;
    b = nbb;
    o = obs(id);
    check({tag, "/busy"}, 32'(o[8:7]), 32'b10);
    n = 0;
    got = 1'b0;
    while (n < 20 && !got) begin
      step();
      n++;
      o = obs(id);
      if (o[7]) got = 1'b1;
    end
    check({tag, "/lat"}, 32'(n), 32'(ek));
    check({tag, "/res"}, 32'(o[6:0]), 32'(exp_res));
    step();
    o = obs(id);
    check({tag, "/idle"}, 32'(o[8:7]), 32'b00);
    check({tag, "/hold"}, 32'(o[6:0]), 32'(exp_res));
  endtask

  initial begin
    logic [8:0] o;
    int n;
    bit seen;
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    start_v = '0;
    a       = 8'h00;
    b       = 8'h00;
    #12;
    for (int i = 0; i < 4; i++) check($sformatf("reset%0d", i), 32'(obs(i)), 32'h0);
    step();
    rst = 1'b0;
    step();

    // Directed early-exit and full-scan cases.
    run_one("t1", 0, 8'h80, 8'h7F, 8'h80, 8'h7F, 1'b0, 1'b1, 1'b0, 1);
    run_one("t2", 0, 8'h35, 8'h35, 8'h35, 8'h35, 1'b0, 1'b0, 1'b1, 8);
    run_one("t3ee0", 1, 8'h12, 8'h13, 8'h12, 8'h13, 1'b1, 1'b0, 1'b0, 8);
    run_one("t3ee1", 0, 8'h12, 8'h13, 8'h12, 8'h13, 1'b1, 1'b0, 1'b0, 8);
    run_one("ee0gt", 1, 8'hA5, 8'h25, 8'hA5, 8'h25, 1'b0, 1'b1, 1'b0, 8);

    // Start held high through RUN/DONE; second request accepted on the first IDLE edge.
    a = 8'h40;
    b = 8'h00;
    start_v[0] = 1'b1;
    step();
    a = 8'h01;
    b = 8'h02;
    step();
    o = obs(0);
    check("t4/run", 32'(o[8:7]), 32'b10);
    step();
    o = obs(0);
    check("t4/done", 32'(o[8:7]), 32'b11);
    check("t4/res", 32'(o[6:0]), 32'({3'b010, 4'd2}));
    step();
    o = obs(0);
    check("t4/idle", 32'(o[8:7]), 32'b00);
    check("t4/hold", 32'(o[6:0]), 32'({3'b010, 4'd2}));
    step();
    o = obs(0);
    check("t4/acc", 32'(o[8:7]), 32'b10);
    check("t4/clr", 32'(o[6:0]), 32'h0);
    start_v[0] = 1'b0;
    n = 0;
    seen = 1'b0;
    while (n < 20 && !seen) begin
      step();
      n++;
      o = obs(0);
      if (o[7]) seen = 1'b1;
    end
    check("t4/lat2", 32'(n), 32'd7);
    check("t4/res2", 32'(o[6:0]), 32'({3'b100, 4'd7}));
    step();

    // Reset asserted mid-run clears everything without a done pulse.
    a = 8'hF0;
    b = 8'h0F;
    start_v[1] = 1'b1;
    step();
    start_v[1] = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    check("t5/async", 32'(obs(1)), 32'h0);
    step();
    step();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done_v[1] || busy_v[1]) seen = 1'b1;
    end
    check("t5/nodone", 32'(seen), 32'd0);
    check("t5/post", 32'(obs(1)), 32'h0);

    // Operands changed after acceptance must not affect the result.
    run_one("t5chg0", 1, 8'hF0, 8'h0F, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b0, 8);
    run_one("t5chg1", 0, 8'h0E, 8'h0F, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 8);

    // Exhaustive 4-bit sweep against both early-exit settings.
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        logic [3:0] av, bv;
        logic [6:0] r2, r3, e2, e3;
        int n2, n3, k1;
        av = 4'(ai);
        bv = 4'(bi);
        k1 = 4;
        for (int j = 0; j < 4; j++) if (av[j] != bv[j]) k1 = 4 - j;
        e2 = {ai < bi, ai > bi, ai == bi, 4'(k1)};
        e3 = {ai < bi, ai > bi, ai == bi, 4'd4};
        a = {4'h0, av};
        b = {4'h0, bv};
        start_v[3:2] = 2'b11;
        step();
        start_v[3:2] = 2'b00;
        n = 0;
        n2 = 0;
        n3 = 0;
        r2 = '0;
        r3 = '0;
        while (n < 10 && (n2 == 0 || n3 == 0)) begin
          step();
          n++;
          if (done_v[2] && n2 == 0) begin n2 = n; r2 = obs(2)  ; end
          if (done_v[3] && n3 == 0) begin n3 = n; r3 = obs(3)  ; end
        end
        check($sformatf("sw_ee1_%0h_%0h/lat", ai, bi), 32'(n2), 32'(k1));
        check($sformatf("sw_ee1_%0h_%0h/res", ai, bi), 32'(r2), 32'(e2));
        check($sformatf("sw_ee0_%0h_%0h/lat", ai, bi), 32'(n3), 32'd4);
        check($sformatf("sw_ee0_%0h_%0h/res", ai, bi), 32'(r3), 32'(e3));
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
